// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - parametrised big-endian data-memory controller with req/ready handshake
//
// Purpose: byte/halfword/word loads and stores into a DEPTH_WORDS x 32 array mapped at
// BASE_ADDR, with WAIT_STATES extra cycles per legal access and error reporting for
// misaligned, reserved-size and out-of-window requests.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          access request, sampled only in IDLE
//   we           1 = store, 0 = load
//   size         00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext     loads: 1 sign-extends, 0 zero-extends byte/halfword
//   address      byte address
//   write_data   store data, right-justified
//   ready        one-cycle completion pulse
//   read_data    load result, held until the next completed load
//   err_misalign with ready: alignment or reserved-size rejection
//   err_range    with ready: address outside the window
module dmem_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h7FFFFC00,
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        ready,
   output logic [31:0] read_data,
   output logic        err_misalign,
   output logic        err_range
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // 33-bit upper bound so a window ending at 0xFFFFFFFF does not wrap to 0
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;

   logic          l_we;
   logic [1:0]    l_size;
   logic          l_sext;
   logic [1:0]    l_off;
   logic [IW-1:0] l_idx;
   logic [31:0]   l_wdata;
   logic          l_mis;
   logic          l_rng;

   logic [31:0] mem [DEPTH_WORDS];

   logic        chk_mis;
   logic        chk_rng;
   logic [31:0] cur_word;
   logic [31:0] st_word;
   logic [31:0] ld_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      chk_mis = (size == 2'b11)
             || (size == 2'b01 && address[0])
             || (size == 2'b10 && address[1:0] != 2'b00);
      chk_rng = ({1'b0, address} < {1'b0, BASE_ADDR}) || ({1'b0, address} >= LIMIT);
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (chk_mis || chk_rng) begin
                  state_n = S_ERR;
               end else if (WAIT_STATES == 0) begin
                  state_n = S_ACCESS;
               end else begin
                  state_n = S_WAIT;
                  cnt_n   = 4'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_n = S_ACCESS;
            else             cnt_n   = cnt - 4'd1;
         end
         S_ACCESS: state_n = S_IDLE;
         S_ERR:    state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_we    <= 1'b0;
         l_size  <= 2'b00;
         l_sext  <= 1'b0;
         l_off   <= 2'b00;
         l_idx   <= '0;
         l_wdata <= 32'h0;
         l_mis   <= 1'b0;
         l_rng   <= 1'b0;
      end else if (state == S_IDLE && req) begin
         l_we    <= we;
         l_size  <= size;
         l_sext  <= sign_ext;
         l_off   <= address[1:0];
         l_idx   <= IW'((address - BASE_ADDR) >> 2);
         l_wdata <= write_data;
         l_mis   <= chk_mis;
         l_rng   <= chk_rng;
      end
   end

   // Lane select and merge: offset 0 is the most significant byte.
   assign cur_word = mem[l_idx];

   always_comb begin
      st_word = cur_word;
      ld_word = cur_word;
      case (l_off)
         2'd0:    ld_byte = cur_word[31:24];
         2'd1:    ld_byte = cur_word[23:16];
         2'd2:    ld_byte = cur_word[15:8];
         default: ld_byte = cur_word[7:0];
      endcase
      ld_half = l_off[1] ? cur_word[15:0] : cur_word[31:16];
      case (l_size)
         2'b00: begin
            ld_word = l_sext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            case (l_off)
               2'd0:    st_word[31:24] = l_wdata[7:0];
               2'd1:    st_word[23:16] = l_wdata[7:0];
               2'd2:    st_word[15:8]  = l_wdata[7:0];
               default: st_word[7:0]   = l_wdata[7:0];
            endcase
         end
         2'b01: begin
            ld_word = l_sext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            if (l_off[1]) st_word[15:0]  = l_wdata[15:0];
            else          st_word[31:16] = l_wdata[15:0];
         end
         default: st_word = l_wdata;
      endcase
   end

   // Array is not reset; an async reset forces IDLE so a pending store never commits.
   always_ff @(posedge clk) begin
      if (state == S_ACCESS && l_we) mem[l_idx] <= st_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready        <= 1'b0;
         err_misalign <= 1'b0;
         err_range    <= 1'b0;
         read_data    <= 32'h0;
      end else begin
         ready        <= (state == S_ACCESS) || (state == S_ERR);
         err_misalign <= (state == S_ERR) && l_mis;
         err_range    <= (state == S_ERR) && l_rng;
         if (state == S_ACCESS && !l_we) read_data <= ld_word;
      end
   end

endmodule
